adpll_lock_detector: RTL and testbench
======================================

Name: adpll_lock_detector

Overview:
- Sits directly downstream of the ADPLL controller.
- Samples the controller's corrected frequency error and DCO code once per loop update.
- Declares lock after a programmable run of consecutive in-window samples, and drops lock after a programmable run of out-of-window samples.
- Gathers lock statistics (acquisition time, DCO min/max, lock-loss count) for readout through the BIST scan chain.

Parameters:
- ERR_W, 14, width of the signed frequency error
- DCO_W, 13, width of the DCO control code
- CNT_W, 11, width of the locktime and acquisition counters
- LOSS_W, 8, width of the lock-loss counter

Ports:
- ref_clk  in  1  sole clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  detector enable; low forces IDLE
- err_valid  in  1  one-cycle strobe, one per controller loop update
- freq_error  in  ERR_W  signed corrected frequency error
- dco_code  in  DCO_W  unsigned filter output / DCO input code
- tol_pos  in  ERR_W  unsigned positive tolerance magnitude
- tol_neg  in  ERR_W  unsigned negative tolerance magnitude
- locktime  in  CNT_W  consecutive in-window samples needed to lock
- unlock_count  in  4  consecutive out-of-window samples needed to drop lock
- clear_stats  in  1  synchronous clear of the statistics registers
- lock  out  1  lock indicator
- state  out  2  FSM state: IDLE=0, ACQUIRE=1, LOCKED=2, SLIP=3
- acq_cycles  out  CNT_W  samples spent in the current or last acquisition, saturating
- dco_at_lock  out  DCO_W  dco_code captured on the sample that achieved lock
- dco_min  out  DCO_W  minimum in-window dco_code while locked
- dco_max  out  DCO_W  maximum in-window dco_code while locked
- loss_count  out  LOSS_W  number of lock losses, saturating
- sticky_unlock  out  1  see Optional Feature

Behaviour:
- Reset values:
  - state=IDLE, lock=0, acq_cycles=0, dco_at_lock=0, loss_count=0, sticky_unlock=0
  - dco_min = all-ones, dco_max = 0
  - Internal run counters = 0.
- Window test is combinational:
  - in_win = (freq_error >= -tol_neg) && (freq_error <= tol_pos).
  - Evaluate in ERR_W+1 signed so that tol = 2^(ERR_W-1) cannot overflow.
- Sample qualification:
  - FSM and counters change only on cycles with err_valid=1, except for enable, reset and clear_stats.
  - Outputs are registered; every effect appears the cycle after the causing sample.
- IDLE:
  - lock=0 and the run counters are held at 0.
  - enable=1 moves to ACQUIRE the next cycle and clears acq_cycles and the in-run counter.
- ACQUIRE, on each sample:
  - acq_cycles increments, saturating at 2^CNT_W-1.
  - If in_win, the in-run counter increments; otherwise it clears to 0.
  - When the in-run counter reaches max(locktime,1):
    - move to LOCKED and set lock=1;
    - capture dco_at_lock = dco_min = dco_max = dco_code.
- LOCKED:
  - An in_win sample updates dco_min/dco_max.
  - An out-of-window sample moves to SLIP with the slip counter = 1.
  - If max(unlock_count,1)=1, go directly to ACQUIRE instead, via the loss path.
- SLIP:
  - lock stays 1; min/max are not updated.
  - An in_win sample returns to LOCKED, clears the slip counter and updates min/max.
  - An out-of-window sample increments the slip counter.
- Loss path (slip counter reaches max(unlock_count,1)):
  - move to ACQUIRE and set lock=0;
  - loss_count increments, saturating at 2^LOSS_W-1;
  - clear acq_cycles and the in-run counter.
- enable=0 in any state: IDLE next cycle, lock=0. Statistics are kept, and this does not count as a loss.
- clear_stats:
  - loss_count=0, dco_min=all-ones, dco_max=0, sticky_unlock=0.
  - Does not clear acq_cycles or dco_at_lock.
  - Wins over a simultaneous loss increment or min/max update.
- reset has priority over everything and aborts any operation in progress.
- locktime or unlock_count changed mid-run: the comparison uses the current value. A counter already at or above the new threshold triggers on the next qualifying sample.

Optional Feature:
- Macro ADPLL_LOCK_STICKY_EN.
- Defined: sticky_unlock sets on every loss-path transition and holds until clear_stats or reset.
- Undefined: sticky_unlock is tied to 0, and no flop is instantiated.

Decomposition:
- Package adpll_lock_pkg holds:
  - the state enum (IDLE/ACQUIRE/LOCKED/SLIP, 2-bit encoding as above);
  - default widths ERR_W/DCO_W/CNT_W/LOSS_W;
  - a saturating-increment function.
- One natural sub-module, adpll_window_cmp: a combinational signed window comparator (freq_error, tol_pos, tol_neg -> in_win), reusable for the phase tolerance checks.

Test Plan:
- locktime=4, unlock_count=2, tol_pos=tol_neg=10, enable=1; samples err = 3,-5,12,0,1,2,9 → lock rises the cycle after the 7th sample; acq_cycles=7.
- Boundary check with tol_pos=tol_neg=10:
  - err=+10 and err=-10 are in window;
  - err=+11 and err=-11 are out of window;
  - tol=8192 with err=-8192 is in window, with no overflow.
- Slip test, LOCKED with unlock_count=2:
  - err sequence 20,0 → passes through SLIP, lock stays 1, loss_count=0.
  - err sequence 20,20 → lock falls, state=ACQUIRE, loss_count=1.
- Statistics while locked:
  - dco_code 100,97,105 in window → dco_min=97, dco_max=105, dco_at_lock = the code on the locking sample.
  - clear_stats on the same cycle as a loss → loss_count=0.
- Enable/reset interaction:
  - enable drops while LOCKED → IDLE and lock=0 next cycle, loss_count unchanged.
  - reset mid-ACQUIRE → all outputs return to their reset values.
- Saturation and macro:
  - Force 300 losses with LOSS_W=8 → loss_count=255.
  - With ADPLL_LOCK_STICKY_EN, sticky_unlock=1 after the first loss.
  - Without the macro, sticky_unlock stays 0.

Source files
------------

// File: rtl/adpll_lock_pkg.sv
// Shared types, default widths and helpers for the ADPLL lock detector.
package adpll_lock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    SLIP    = 2'd3
  } lock_state_t;

  localparam int ERR_W_DEFAULT  = 14;
  localparam int DCO_W_DEFAULT  = 13;
  localparam int CNT_W_DEFAULT  = 11;
  localparam int LOSS_W_DEFAULT = 8;

  // Increment that sticks at the all-ones value of a 'width'-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (32'd1 << width) - 32'd1;
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/adpll_window_cmp.sv
// Combinational signed window test: in_win = -tol_neg <= freq_error <= tol_pos.
module adpll_window_cmp
  import adpll_lock_pkg::*;
#(
  parameter int W = ERR_W_DEFAULT
) (
  input  logic [W-1:0] freq_error,
  input  logic [W-1:0] tol_pos,
  input  logic [W-1:0] tol_neg,
  output logic         in_win
);

  // One extra bit keeps a tolerance of 2^(W-1) and its negation representable.
  logic signed [W:0] err_ext;
  logic signed [W:0] pos_lim;
  logic signed [W:0] neg_lim;

  assign err_ext = {freq_error[W-1], freq_error};
  assign pos_lim = {1'b0, tol_pos};
  assign neg_lim = -$signed({1'b0, tol_neg});
  assign in_win  = (err_ext >= neg_lim) && (err_ext <= pos_lim);

endmodule

// File: rtl/adpll_lock_detector.sv
// ADPLL lock detector: lock/unlock FSM with acquisition and DCO statistics.
// Optional sticky unlock flag enabled by defining ADPLL_LOCK_STICKY_EN.
module adpll_lock_detector
  import adpll_lock_pkg::*;
#(
  parameter int ERR_W  = ERR_W_DEFAULT,
  parameter int DCO_W  = DCO_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter int LOSS_W = LOSS_W_DEFAULT
) (
  input  logic              ref_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              err_valid,
  input  logic [ERR_W-1:0]  freq_error,
  input  logic [DCO_W-1:0]  dco_code,
  input  logic [ERR_W-1:0]  tol_pos,
  input  logic [ERR_W-1:0]  tol_neg,
  input  logic [CNT_W-1:0]  locktime,
  input  logic [3:0]        unlock_count,
  input  logic              clear_stats,
  output logic              lock,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  acq_cycles,
  output logic [DCO_W-1:0]  dco_at_lock,
  output logic [DCO_W-1:0]  dco_min,
  output logic [DCO_W-1:0]  dco_max,
  output logic [LOSS_W-1:0] loss_count,
  output logic              sticky_unlock
);

  lock_state_t       state_reg, state_next;
  logic              lock_reg, lock_next;
  logic [CNT_W-1:0]  acq_reg, acq_next;
  logic [CNT_W-1:0]  run_reg, run_next;
  logic [3:0]        slip_reg, slip_next;
  logic [DCO_W-1:0]  at_lock_reg, at_lock_next;
  logic [DCO_W-1:0]  min_reg, min_next;
  logic [DCO_W-1:0]  max_reg, max_next;
  logic [LOSS_W-1:0] loss_reg, loss_next;

  logic              in_win;
  logic [CNT_W-1:0]  lock_thr;
  logic [3:0]        unlock_thr;
  logic [CNT_W-1:0]  acq_inc;
  logic [CNT_W-1:0]  run_cand;
  logic [3:0]        slip_cand;
  logic [LOSS_W-1:0] loss_inc;
  logic              lock_hit;
  logic              loss_hit;

  adpll_window_cmp #(.W(ERR_W)) u_window (
    .freq_error (freq_error),
    .tol_pos    (tol_pos),
    .tol_neg    (tol_neg),
    .in_win     (in_win)
  );

  // Zero thresholds behave as one; >= lets a lowered threshold fire immediately.
  assign lock_thr   = (locktime == '0) ? CNT_W'(1) : locktime;
  assign unlock_thr = (unlock_count == 4'd0) ? 4'd1 : unlock_count;
  assign acq_inc    = CNT_W'(sat_inc(32'(acq_reg), CNT_W));
  assign run_cand   = in_win ? CNT_W'(sat_inc(32'(run_reg), CNT_W)) : '0;
  assign slip_cand  = (state_reg == LOCKED) ? 4'd1 : 4'(sat_inc(32'(slip_reg), 4));
  assign loss_inc   = LOSS_W'(sat_inc(32'(loss_reg), LOSS_W));

  assign lock_hit = enable && err_valid && (state_reg == ACQUIRE) && (run_cand >= lock_thr);
  assign loss_hit = enable && err_valid && !in_win &&
                    ((state_reg == LOCKED) || (state_reg == SLIP)) &&
                    (slip_cand >= unlock_thr);

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = ACQUIRE;
        ACQUIRE: if (lock_hit) state_next = LOCKED;
        LOCKED:  if (err_valid && !in_win) state_next = loss_hit ? ACQUIRE : SLIP;
        SLIP: begin
          if (err_valid) begin
            if (in_win) begin
              state_next = LOCKED;
            end else if (loss_hit) begin
              state_next = ACQUIRE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    lock_next    = (state_next == LOCKED) || (state_next == SLIP);
    acq_next     = acq_reg;
    run_next     = run_reg;
    slip_next    = slip_reg;
    at_lock_next = at_lock_reg;
    min_next     = min_reg;
    max_next     = max_reg;
    loss_next    = loss_reg;
    if (!enable) begin
      run_next  = '0;
      slip_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          acq_next  = '0;
          run_next  = '0;
          slip_next = '0;
        end
        ACQUIRE: begin
          if (err_valid) begin
            acq_next = acq_inc;
            run_next = run_cand;
            if (lock_hit) begin
              at_lock_next = dco_code;
              min_next     = dco_code;
              max_next     = dco_code;
              run_next     = '0;
            end
          end
        end
        LOCKED, SLIP: begin
          if (err_valid) begin
            if (in_win) begin
              slip_next = '0;
              min_next  = (dco_code < min_reg) ? dco_code : min_reg;
              max_next  = (dco_code > max_reg) ? dco_code : max_reg;
            end else if (!loss_hit) begin
              slip_next = slip_cand;
            end
          end
        end
        default: ;
      endcase
      if (loss_hit) begin
        acq_next  = '0;
        run_next  = '0;
        slip_next = '0;
        loss_next = loss_inc;
      end
    end
    // Clearing statistics overrides any same-cycle update of them.
    if (clear_stats) begin
      loss_next = '0;
      min_next  = '1;
      max_next  = '0;
    end
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      lock_reg    <= 1'b0;
      acq_reg     <= '0;
      run_reg     <= '0;
      slip_reg    <= '0;
      at_lock_reg <= '0;
      min_reg     <= '1;
      max_reg     <= '0;
      loss_reg    <= '0;
    end else begin
      lock_reg    <= lock_next;
      acq_reg     <= acq_next;
      run_reg     <= run_next;
      slip_reg    <= slip_next;
      at_lock_reg <= at_lock_next;
      min_reg     <= min_next;
      max_reg     <= max_next;
      loss_reg    <= loss_next;
    end
  end

`ifdef ADPLL_LOCK_STICKY_EN
  logic sticky_reg;

  always_ff @(posedge ref_clk) begin
    if (reset || clear_stats) begin
      sticky_reg <= 1'b0;
    end else if (loss_hit) begin
      sticky_reg <= 1'b1;
    end
  end

  assign sticky_unlock = sticky_reg;
`else
  assign sticky_unlock = 1'b0;
`endif

  assign lock        = lock_reg;
  assign state       = state_reg;
  assign acq_cycles  = acq_reg;
  assign dco_at_lock = at_lock_reg;
  assign dco_min     = min_reg;
  assign dco_max     = max_reg;
  assign loss_count  = loss_reg;

endmodule

// File: tb/tb_adpll_lock_detector.sv
// Scoreboard bench for adpll_lock_detector: a behavioural model predicts every
// cycle's outputs, a monitor compares them; directed test-plan steps then random traffic.
module tb_adpll_lock_detector;

  localparam int ERR_W  = 14;
  localparam int DCO_W  = 13;
  localparam int CNT_W  = 11;
  localparam int LOSS_W = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int LMAX   = (1 << LOSS_W) - 1;
  localparam int DMAX   = (1 << DCO_W) - 1;

  logic              ref_clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              err_valid = 1'b0;
  logic [ERR_W-1:0]  freq_error = '0;
  logic [DCO_W-1:0]  dco_code = '0;
  logic [ERR_W-1:0]  tol_pos = '0;
  logic [ERR_W-1:0]  tol_neg = '0;
  logic [CNT_W-1:0]  locktime = '0;
  logic [3:0]        unlock_count = '0;
  logic              clear_stats = 1'b0;
  logic              lock;
  logic [1:0]        state;
  logic [CNT_W-1:0]  acq_cycles;
  logic [DCO_W-1:0]  dco_at_lock;
  logic [DCO_W-1:0]  dco_min;
  logic [DCO_W-1:0]  dco_max;
  logic [LOSS_W-1:0] loss_count;
  logic              sticky_unlock;

  adpll_lock_detector #(
    .ERR_W(ERR_W), .DCO_W(DCO_W), .CNT_W(CNT_W), .LOSS_W(LOSS_W)
  ) dut (
    .ref_clk       (ref_clk),
    .reset         (reset),
    .enable        (enable),
    .err_valid     (err_valid),
    .freq_error    (freq_error),
    .dco_code      (dco_code),
    .tol_pos       (tol_pos),
    .tol_neg       (tol_neg),
    .locktime      (locktime),
    .unlock_count  (unlock_count),
    .clear_stats   (clear_stats),
    .lock          (lock),
    .state         (state),
    .acq_cycles    (acq_cycles),
    .dco_at_lock   (dco_at_lock),
    .dco_min       (dco_min),
    .dco_max       (dco_max),
    .loss_count    (loss_count),
    .sticky_unlock (sticky_unlock)
  );

  always #5 ref_clk = ~ref_clk;

  typedef struct packed {
    logic              lock;
    logic [1:0]        st;
    logic [CNT_W-1:0]  acq;
    logic [DCO_W-1:0]  at;
    logic [DCO_W-1:0]  mn;
    logic [DCO_W-1:0]  mx;
    logic [LOSS_W-1:0] loss;
    logic              sticky;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  exp_t q[$];
  obs_t obs;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  assign obs = {lock, state, acq_cycles, dco_at_lock, dco_min, dco_max, loss_count, sticky_unlock};

  always @(posedge ref_clk) cyc <= cyc + 1;

  // Reference model: mode 0=idle 1=acquiring 2=locked 3=slipping.
  int m_mode = 0, m_acq = 0, m_run = 0, m_slip = 0;
  int m_at = 0, m_min = DMAX, m_max = 0, m_loss = 0;
  bit m_sticky = 0;

  task automatic model_update();
    int e, lthr, uthr, dco;
    bit inw, lost;
    e    = $signed(freq_error);
    inw  = (e >= -int'(tol_neg)) && (e <= int'(tol_pos));
    lthr = (locktime == 0) ? 1 : int'(locktime);
    uthr = (unlock_count == 0) ? 1 : int'(unlock_count);
    dco  = int'(dco_code);
    lost = 0;
    if (reset) begin
      m_mode = 0; m_acq = 0; m_run = 0; m_slip = 0;
      m_at = 0; m_min = DMAX; m_max = 0; m_loss = 0; m_sticky = 0;
      return;
    end
    if (!enable) begin
      m_mode = 0; m_run = 0; m_slip = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_acq = 0; m_run = 0; m_slip = 0;
    end else if (err_valid) begin
      if (m_mode == 1) begin
        m_acq = (m_acq < CMAX) ? m_acq + 1 : CMAX;
        m_run = inw ? m_run + 1 : 0;
        if (m_run >= lthr) begin
          m_mode = 2; m_at = dco; m_min = dco; m_max = dco;
        end
      end else if (inw) begin
        m_mode = 2; m_slip = 0;
        if (dco < m_min) m_min = dco;
        if (dco > m_max) m_max = dco;
      end else begin
        m_slip = (m_mode == 2) ? 1 : m_slip + 1;
        if (m_slip >= uthr) lost = 1;
        else m_mode = 3;
      end
    end
    if (lost) begin
      m_mode = 1; m_acq = 0; m_run = 0; m_slip = 0; m_sticky = 1;
      if (m_loss < LMAX) m_loss = m_loss + 1;
    end
    if (clear_stats) begin
      m_loss = 0; m_min = DMAX; m_max = 0; m_sticky = 0;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.lock = (m_mode == 2) || (m_mode == 3);
    o.st   = 2'(m_mode);
    o.acq  = CNT_W'(m_acq);
    o.at   = DCO_W'(m_at);
    o.mn   = DCO_W'(m_min);
    o.mx   = DCO_W'(m_max);
    o.loss = LOSS_W'(m_loss);
`ifdef ADPLL_LOCK_STICKY_EN
    o.sticky = m_sticky;
`else
    o.sticky = 1'b0;
`endif
    return o;
  endfunction

  // Predict the outputs the current inputs will produce, then clock them in.
  task automatic step();
    exp_t x;
    model_update();
    x.cyc = cyc + 1;
    x.o   = model_obs();
    q.push_back(x);
    @(posedge ref_clk);
    #1;
  endtask

  task automatic smp(input int err, input int dco);
    err_valid  = 1'b1;
    freq_error = ERR_W'(err);
    dco_code   = DCO_W'(dco);
    step();
    err_valid  = 1'b0;
    step();
  endtask

  task automatic expect_val(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end else begin
      $display("check %s = %0d ok", name, got);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge ref_clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        x = q.pop_front();
        n_cmp++;
        if (obs !== x.o) begin
          n_bad++;
          $display("FAIL scoreboard cyc=%0d got lock=%0d st=%0d acq=%0d at=%0d min=%0d max=%0d loss=%0d sticky=%0d, expected lock=%0d st=%0d acq=%0d at=%0d min=%0d max=%0d loss=%0d sticky=%0d",
                   x.cyc, obs.lock, obs.st, obs.acq, obs.at, obs.mn, obs.mx, obs.loss, obs.sticky,
                   x.o.lock, x.o.st, x.o.acq, x.o.at, x.o.mn, x.o.mx, x.o.loss, x.o.sticky);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int exp_sticky;
`ifdef ADPLL_LOCK_STICKY_EN
    exp_sticky = 1;
`else
    exp_sticky = 0;
`endif
    repeat (3) step();
    expect_val("reset_state", int'(state), 0);
    expect_val("reset_min", int'(dco_min), DMAX);
    reset = 1'b0;

    // Acquisition: lock after the 7th sample with acq_cycles=7.
    enable = 1'b1; locktime = 11'd4; unlock_count = 4'd2; tol_pos = 14'd10; tol_neg = 14'd10;
    step();
    smp(3, 100); smp(-5, 100); smp(12, 100); smp(0, 100); smp(1, 100); smp(2, 100);
    expect_val("no_lock_before_7th", int'(lock), 0);
    smp(9, 100);
    expect_val("lock_after_7th", int'(lock), 1);
    expect_val("acq_cycles", int'(acq_cycles), 7);

    // Statistics while locked.
    smp(0, 97); smp(1, 105);
    expect_val("dco_min", int'(dco_min), 97);
    expect_val("dco_max", int'(dco_max), 105);
    expect_val("dco_at_lock", int'(dco_at_lock), 100);

    // Slip and recover, then slip to loss.
    smp(20, 300);
    expect_val("slip_state", int'(state), 3);
    expect_val("slip_lock", int'(lock), 1);
    smp(0, 101);
    expect_val("recover_state", int'(state), 2);
    expect_val("recover_loss", int'(loss_count), 0);
    smp(20, 5); smp(20, 5);
    expect_val("loss_lock", int'(lock), 0);
    expect_val("loss_state", int'(state), 1);
    expect_val("loss_count", int'(loss_count), 1);
    expect_val("sticky_first_loss", int'(sticky_unlock), exp_sticky);

    // Window edges: +/-10 in, +/-11 out.
    smp(10, 50); smp(-10, 50); smp(11, 50);
    expect_val("edge_out_pos", int'(state), 1);
    smp(-11, 50); smp(10, 50); smp(-10, 50); smp(10, 50);
    expect_val("edge_not_yet", int'(state), 1);
    smp(-10, 50);
    expect_val("edge_lock", int'(state), 2);

    // Enable drop while locked.
    enable = 1'b0; step();
    expect_val("disable_state", int'(state), 0);
    expect_val("disable_loss", int'(loss_count), 1);
    enable = 1'b1; step();

    // Full-scale tolerance.
    tol_pos = 14'd8192; tol_neg = 14'd8192; locktime = 11'd1;
    smp(-8192, 70);
    expect_val("full_scale_lock", int'(state), 2);
    smp(8191, 71);
    tol_pos = 14'd10; tol_neg = 14'd10; locktime = 11'd4;

    // clear_stats on the loss cycle.
    smp(20, 70);
    clear_stats = 1'b1;
    smp(20, 70);
    clear_stats = 1'b0;
    expect_val("clear_vs_loss", int'(loss_count), 0);
    expect_val("clear_state", int'(state), 1);

    // Reset mid-acquisition.
    smp(0, 1); smp(0, 1);
    reset = 1'b1; step();
    expect_val("mid_reset_acq", int'(acq_cycles), 0);
    reset = 1'b0; step();

    // 300 losses saturate the counter.
    locktime = 11'd1; unlock_count = 4'd1; err_valid = 1'b1; dco_code = 13'd42;
    for (int i = 0; i < 300; i++) begin
      freq_error = 14'd0; step();
      freq_error = 14'd20; step();
    end
    err_valid = 1'b0; step();
    expect_val("loss_saturated", int'(loss_count), LMAX);
    expect_val("sticky_after_losses", int'(sticky_unlock), exp_sticky);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      enable       = ($urandom_range(0, 49) != 0);
      err_valid    = ($urandom_range(0, 9) < 6);
      freq_error   = ERR_W'(int'($urandom_range(0, 50)) - 25);
      dco_code     = DCO_W'($urandom_range(0, DMAX));
      clear_stats  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 49) == 0) tol_pos = ERR_W'($urandom_range(0, 20));
      if ($urandom_range(0, 49) == 0) tol_neg = ERR_W'($urandom_range(0, 20));
      if ($urandom_range(0, 49) == 0) locktime = CNT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) unlock_count = 4'($urandom_range(0, 5));
      step();
    end
    reset = 1'b0; err_valid = 1'b0; clear_stats = 1'b0;
    step();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge ref_clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
